// File: rtl/sm3_digest_tx.sv
// SM3 digest transmitter: buffers 256-bit digests in a small FIFO and streams
// them MSB-byte-first on a valid/ready byte interface. Define HEX_ASCII_EN to send lowercase hex text.
module sm3_digest_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     sm3_result,
  input  logic             result_vld,
  output logic [7:0]       tx_data,
  output logic             tx_vld,
  output logic             tx_last,
  input  logic             tx_rdy,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] digest_cnt,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef HEX_ASCII_EN
  localparam int IDX_W = 6;
  localparam int STEP  = 4;
`else
  localparam int IDX_W = 5;
  localparam int STEP  = 8;
`endif

  // The last symbol index is all ones in both modes (31 or 63).
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [AW:0]      PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state, state_nxt;

  logic [255:0]      mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty;
  logic              push, pop, drop;
  logic [255:0]      head;

  logic [255:0]      sreg;
  logic [255:0]      sreg_shift;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  idx_inc;
  logic              hs;
  logic              advance;
  logic              finish;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] char_of(input logic [STEP-1:0] v);
`ifdef HEX_ASCII_EN
    return hex_char(v);
`else
    return v;
`endif
  endfunction

  // ---- FIFO status and handshake decode
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign hs         = tx_vld & tx_rdy;
  assign push       = result_vld & (~full | pop);
  assign drop       = result_vld & full & ~pop;
  assign sreg_shift = sreg << STEP;
  assign idx_inc    = byte_idx + IDX_ONE;
  assign busy       = ~empty | (state == SEND);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (byte_idx != LAST_IDX) begin
            advance = 1'b1;
          end else begin
            finish = 1'b1;
            // Reload in the same edge keeps tx_vld high between digests.
            if (!empty) pop = 1'b1;
            else        state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- Control state: FSM, pointers, flags, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_vld     <= 1'b0;
      tx_last    <= 1'b0;
      tx_data    <= 8'h00;
      byte_idx   <= '0;
      digest_cnt <= '0;
    end else begin
      if (pop) begin
        tx_vld   <= 1'b1;
        tx_last  <= 1'b0;
        tx_data  <= char_of(head[255 -: STEP]);
        byte_idx <= '0;
      end else if (advance) begin
        tx_last  <= (idx_inc == LAST_IDX);
        tx_data  <= char_of(sreg_shift[255 -: STEP]);
        byte_idx <= idx_inc;
      end else if (finish) begin
        tx_vld  <= 1'b0;
        tx_last <= 1'b0;
      end
      if (finish) digest_cnt <= digest_cnt + CNT_ONE;
    end
  end

  // ---- Datapath storage (no reset: contents qualified by pointers/tx_vld)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sm3_result;
  end

  always_ff @(posedge clk) begin
    if (pop)          sreg <= head;
    else if (advance) sreg <= sreg_shift;
  end

endmodule

// File: doc/sm3_digest_tx.md
Name: sm3_digest_tx

Overview:
- Downstream stage of the SM3 hash core. Captures each 256-bit digest on its one-cycle valid pulse and queues it in a small digest FIFO.
- Serializes each digest MSB-byte-first onto a byte stream with a valid/ready handshake and a last marker.
- Feeds the Ethernet transmit payload path, which returns digests to the host.

Parameters:
- DEPTH, 4, number of 256-bit digest entries buffered; power of two, 2..16.
- CNT_W, 16, width of the sent-digest counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sm3_result  input  256  digest from the SM3 core; sampled only when result_vld=1
- result_vld  input  1  one-cycle digest strobe
- tx_data  output  8  payload byte
- tx_vld  output  1  tx_data valid
- tx_last  output  1  marks the final byte of a digest
- tx_rdy  input  1  downstream accepts the byte when tx_vld & tx_rdy
- ovf  output  1  sticky: a digest was dropped because the FIFO was full
- ovf_clr  input  1  clears ovf
- digest_cnt  output  CNT_W  count of fully transmitted digests; wraps modulo 2^CNT_W
- busy  output  1  FIFO not empty or serializer active

Behaviour:
- Reset (synchronous, active-high): FIFO emptied, FSM to IDLE. tx_data=0, tx_vld=0, tx_last=0, ovf=0, digest_cnt=0, busy=0.
- Reset mid-digest: the partial digest is discarded, no tx_last is issued, and FIFO contents are lost.
- FIFO write: when result_vld=1 and (not full, or a pop occurs in the same cycle), sm3_result is written.
  - If full with no same-cycle pop: the write is dropped and ovf<=1.
  - ovf_clr and a simultaneous drop in the same cycle leave ovf=1; set wins.
- FIFO storage: registers, with pointers of log2(DEPTH)+1 bits and full/empty derived from pointer MSB comparison.
- FSM has two states:
  - IDLE: if FIFO not empty, pop the head into a 256-bit shift register, byte_idx<=0, tx_vld<=1, tx_data<=head[255:248]; go to SEND.
  - SEND, on handshake (tx_vld & tx_rdy):
    - If byte_idx<31: shift left 8, byte_idx++, tx_data<=next byte.
    - If byte_idx==31 (tx_last=1): digest_cnt++.
      - If FIFO not empty: pop and load the next digest in the same edge, so tx_vld stays 1 with zero bubble.
      - Otherwise: tx_vld<=0 and go to IDLE.
- Latency: result_vld in cycle N (FIFO empty, IDLE) gives tx_vld=1 with byte 0 in cycle N+2.
- Handshake rules:
  - While tx_vld=1 and tx_rdy=0, tx_data and tx_last are held stable.
  - tx_vld never deasserts without a handshake.
  - tx_rdy is ignored when tx_vld=0.
- tx_last: tx_last = tx_vld & (byte_idx==last index); it is registered alongside tx_data.
- busy: busy = !empty | (state==SEND).
- Byte order: sm3_result[255:248] first, [7:0] last.

Optional Feature:
- Macro HEX_ASCII_EN.
- Defined: each digest is sent as 64 lowercase ASCII hex characters, high nibble first ('0'-'9' = 8'h30-8'h39, 'a'-'f' = 8'h61-8'h66).
  - byte_idx widens to 6 bits; tx_last is asserted on character 63.
  - The shift register shifts 4 bits per handshake.
- Undefined: raw binary, 32 bytes per digest as described above.

Test Plan:
- Single digest of SM3("abc") = 66c7f0f4...8f4ba8e0, tx_rdy=1 -> tx_vld rises at N+2; 32 bytes 8'h66, 8'hc7, ... 8'he0 on consecutive cycles; tx_last on byte 31 only; digest_cnt=1; busy falls after the last handshake.
- Backpressure: tx_rdy toggles 1,0,0,1 repeating -> tx_data and tx_last stable while tx_rdy=0; byte sequence identical to the first test; no duplicated or skipped bytes.
- Back-to-back: 3 digests at result_vld spacing of 2 cycles, tx_rdy=1 -> 96 contiguous bytes with tx_vld never low between digests; tx_last at bytes 31, 63, 95; digest_cnt=3.
- Overflow: tx_rdy=0, write DEPTH+2=6 digests -> first 5 accepted (4 FIFO entries plus 1 in the shift register), 6th dropped, ovf=1. Then ovf_clr=1 -> ovf=0. Write while full with a same-cycle pop (last-byte handshake) -> accepted, ovf stays 0.
- Reset mid-stream: assert rst after byte 10 of a digest -> next cycle tx_vld=0, tx_last=0, digest_cnt=0, busy=0; a new digest afterwards streams from byte 0.
- HEX_ASCII_EN defined: "abc" digest -> 64 characters starting 8'h36, 8'h36, 8'h63, 8'h37 ("66c7"); tx_last on character 63.
